// File: rtl/uart_rx_pkg.sv
// UART definitions shared between the RX and TX sides: FSM state encoding,
// parity type constants and the 3-sample majority helper.
package uart_rx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: edge/bit counters and the mid-bit
// 3-sample majority vote.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESC_W = 6,
   parameter int BIT_W   = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_run,
   input  logic               i_rx,
   input  logic [PRESC_W-1:0] i_presc,
   output logic               o_sampled_bit,
   output logic               o_bit_done,
   output logic [BIT_W-1:0]   o_bit_cnt
);

   logic [PRESC_W-1:0] r_edge_cnt;
   logic [BIT_W-1:0]   r_bit_cnt;
   logic [2:0]         r_smp;
   logic [PRESC_W-1:0] w_half;
   logic               w_last;

   assign w_half = i_presc >> 1;
   assign w_last = (r_edge_cnt == i_presc - PRESC_W'(1));

   // The start edge itself counts as edge 0, so the counter resumes at 1.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (i_start) begin
         r_edge_cnt <= PRESC_W'(1);
         r_bit_cnt  <= '0;
      end else if (i_run) begin
         if (w_last) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
         end else begin
            r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_smp <= '0;
      end else if (i_run) begin
         if (r_edge_cnt == w_half - PRESC_W'(1)) r_smp[0] <= i_rx;
         if (r_edge_cnt == w_half)               r_smp[1] <= i_rx;
         if (r_edge_cnt == w_half + PRESC_W'(1)) r_smp[2] <= i_rx;
      end
   end

   assign o_sampled_bit = maj3(r_smp);
   assign o_bit_done    = i_run & w_last;
   assign o_bit_cnt     = r_bit_cnt;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, WIDTH data bits LSB first, optional parity, one stop
// bit; registered data/valid and one-cycle parity/stop error pulses.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               RX_IN,
   input  logic [PRESC_W-1:0] PRESCALE,
   input  logic               PAR_EN,
   input  logic               PAR_TYP,
   output logic [WIDTH-1:0]   P_DATA,
   output logic               DATA_VALID,
   output logic               PAR_ERR,
   output logic               STP_ERR
);

   localparam int BIT_W = $clog2(WIDTH + 4);

   logic [2:0]         r_state;
   logic [PRESC_W-1:0] r_presc;
   logic               r_par_en;
   logic               r_par_typ;
   logic               r_par_fail;
   logic [WIDTH-1:0]   r_shift;

   logic               w_start;
   logic               w_run;
   logic               w_bit;
   logic               w_done;
   logic [BIT_W-1:0]   w_bit_cnt;
   logic               w_par_exp;

   assign w_start   = (r_state == ST_IDLE) && !RX_IN;
   assign w_run     = (r_state != ST_IDLE);
   assign w_par_exp = (r_par_typ == PAR_EVEN) ? ^r_shift : ~^r_shift;

   uart_rx_sampler #(
      .PRESC_W (PRESC_W),
      .BIT_W   (BIT_W)
   ) u_sampler (
      .i_clk         (CLK),
      .i_rst         (RST),
      .i_start       (w_start),
      .i_run         (w_run),
      .i_rx          (RX_IN),
      .i_presc       (r_presc),
      .o_sampled_bit (w_bit),
      .o_bit_done    (w_done),
      .o_bit_cnt     (w_bit_cnt)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         r_presc    <= '0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_par_fail <= 1'b0;
         r_shift    <= '0;
         P_DATA     <= '0;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
      end else begin
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Config is frozen for the frame so a mid-frame change cannot skew timing.
               if (!RX_IN) begin
                  r_state    <= ST_START;
                  r_presc    <= PRESCALE;
                  r_par_en   <= PAR_EN;
                  r_par_typ  <= PAR_TYP;
                  r_par_fail <= 1'b0;
               end
            end
            ST_START: begin
               if (w_done) r_state <= w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               if (w_done) begin
                  r_shift <= {w_bit, r_shift[WIDTH-1:1]};
                  if (w_bit_cnt == BIT_W'(WIDTH))
                     r_state <= r_par_en ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               if (w_done) begin
                  if (w_bit != w_par_exp) begin
                     r_par_fail <= 1'b1;
                     PAR_ERR    <= 1'b1;
                  end
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_done) begin
                  r_state <= ST_IDLE;
                  if (!w_bit) begin
                     STP_ERR <= 1'b1;
                  end else if (!r_par_fail) begin
                     P_DATA     <= r_shift;
                     DATA_VALID <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver matching the system's UART transmitter: start bit, WIDTH data bits LSB first, optional parity bit, one stop bit.
- Oversamples RX_IN at PRESCALE clocks per bit and recovers each bit by 3-sample majority vote.
- Delivers the parallel word with a one-cycle DATA_VALID pulse; flags parity and stop-bit errors.
- Sits between the serial pin (already synchronized upstream) and the register-file/command controller.

Parameters:
WIDTH, 8, data bits per frame
PRESC_W, 6, width of PRESCALE input (supports up to 32x oversampling)

Ports:
CLK  input  1  system clock (the RX clock domain)
RST  input  1  synchronous, active-high reset
RX_IN  input  1  serial line, idle high, already synchronized to CLK
PRESCALE  input  PRESC_W  oversampling ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  WIDTH  last correctly received word
DATA_VALID  output  1  one-cycle pulse: P_DATA updated
PAR_ERR  output  1  one-cycle pulse: parity mismatch
STP_ERR  output  1  one-cycle pulse: stop bit sampled 0

Behaviour:
- Reset: one clock and reset. Reset is synchronous and active-high, named RST. On reset: state IDLE, counters 0, P_DATA = 0, DATA_VALID = PAR_ERR = STP_ERR = 0. Reset mid-frame discards the frame with no pulses.
- Configuration: PRESCALE, PAR_EN and PAR_TYP are captured at start detection and held for the whole frame.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 within each bit and wraps to 0.
  - bit_cnt increments on each wrap.
- Sampling:
  - RX_IN is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The majority of the three samples gives sampled_bit, valid from edge_cnt = PRESCALE/2+2.
- Timing reference: t0 is the edge at which IDLE samples RX_IN = 0. That edge is edge_cnt 0 of the start bit.
- FSM states and transitions:
  - IDLE: RX_IN = 0 -> START, edge_cnt = 1. Otherwise stay.
  - START: at edge_cnt = PRESCALE-1, sampled_bit = 0 -> DATA. sampled_bit = 1 -> IDLE (glitch rejected, no pulses).
  - DATA: each bit's sampled_bit is shifted into the shift register LSB first. After WIDTH bits -> PARITY if PAR_EN, else STOP.
  - PARITY: expected bit = XOR of data (even) or its inverse (odd). Mismatch at edge_cnt = PRESCALE-1 sets an internal par_fail flag and pulses PAR_ERR for one cycle -> STOP.
  - STOP: at edge_cnt = PRESCALE-1 -> IDLE.
    - sampled_bit = 0: pulse STP_ERR.
    - sampled_bit = 1 and no par_fail: load P_DATA and pulse DATA_VALID in the same cycle.
- Output timing: with N = 10 + PAR_EN frame bits, DATA_VALID, and STP_ERR when it fires, are high in cycle t0 + N*PRESCALE - 1. PAR_ERR is high in cycle t0 + (N-1)*PRESCALE - 1.
- Error frames: P_DATA keeps its previous value on any error.
- Back-to-back frames: IDLE samples RX_IN on the cycle after STOP ends. A start edge arriving during the final STOP cycle is seen one cycle late, which is tolerated by the mid-bit sampling margin.
- Illegal PRESCALE: values other than 8/16/32 give undefined data. There is no lockup; the FSM always returns to IDLE after N bit periods.
- Outputs are registered; no combinational path from RX_IN to any output.

Decomposition:
- Shared package: UART state encoding (IDLE/START/DATA/PARITY/STOP, 3-bit) and a parity-type constant (EVEN=0, ODD=1), shared with the TX side.
- One sub-module: uart_rx_sampler.
  - Contains edge_cnt, bit_cnt and the 3-sample majority vote.
  - Outputs sampled_bit and a bit_done strobe.
  - The FSM, shift register, parity/stop checks and output registers stay in uart_rx.

Test Plan:
- PRESCALE=8, PAR_EN=1, even parity, frame 0xA5 (parity 0) -> DATA_VALID high only at t0+87, P_DATA=0xA5, no error pulses.
- PRESCALE=16, PAR_EN=1, odd parity, frame 0x3C with parity bit deliberately 0 (correct = 1) -> PAR_ERR pulse at t0+159, no DATA_VALID, P_DATA unchanged.
- PRESCALE=32, PAR_EN=0, frame 0x81 with stop bit 0 -> STP_ERR at t0+319, no DATA_VALID. A following good frame 0x55 yields DATA_VALID with P_DATA=0x55.
- PRESCALE=8, RX_IN low for 3 cycles then high -> START rejects the glitch, returns to IDLE, no pulses. A valid frame immediately after is received correctly.
- PRESCALE=8, single-cycle inverted spikes on samples at edge_cnt 3 of each data bit of 0xF0 -> majority vote recovers 0xF0.
- RST asserted mid-DATA of frame 0x12 -> all outputs 0 the next cycle. The remaining bits are ignored until line idle, and the next frame 0x34 is received correctly.
